fifo_drain: RTL
===============

FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, setting the width of one FIFO entry.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port flush, input, 1 bit: pipeline flush, same effect as rst on all state.
REQ-005 The module SHALL have port fifo_empty, input, 1 bit: empty flag from the upstream FIFO.
REQ-006 The module SHALL have port fifo_pop_data, input, DATA_WIDTH bits: the upstream FIFO head entry, combinational show-ahead, valid whenever fifo_empty=0.
REQ-007 The module SHALL have port fifo_pop, output, 1 bit: dequeue request to the upstream FIFO.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 The module SHALL have port out_data, output, DATA_WIDTH bits: oldest buffered entry.
REQ-010 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 The module SHALL have port occupancy, output, 2 bits: number of buffered entries (0..2).

Function
REQ-012 The block SHALL hold a 2-entry in-order buffer (slot0 = head, slot1 = tail) with state EMPTY (0), ONE (1) or TWO (2), reported on occupancy.
REQ-013 fifo_pop SHALL equal ~fifo_empty & ~flush & ~rst & (occupancy != 2), with no combinational path from out_ready.
REQ-014 On a cycle with fifo_pop=1, fifo_pop_data SHALL be captured into the buffer at that rising edge.
REQ-015 out_valid SHALL equal (occupancy != 0) and be driven from registers only; out_data SHALL be slot0.
REQ-016 A dequeue SHALL occur on any cycle with out_valid & out_ready; when out_valid=0, out_ready SHALL be ignored.
REQ-017 Latency: an entry at the FIFO head in cycle N with the buffer EMPTY SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-018 Transitions: EMPTY+push -> ONE (slot0 = new entry); ONE+push only -> TWO (slot1 = new entry); ONE+dequeue only -> EMPTY; ONE+push+dequeue -> ONE (slot0 = new entry); TWO+dequeue -> ONE (slot0 = old slot1); TWO never pushes.
REQ-019 Steady state with the FIFO non-empty and out_ready held high SHALL sustain one entry per cycle on the output.
REQ-020 Entries SHALL leave in exactly the order popped; no entry SHALL be duplicated or dropped, except by flush/rst.
REQ-021 flush=1 SHALL force fifo_pop=0 in that cycle, discard all buffered entries and set occupancy to 0 at the next edge; a push or dequeue coincident with flush SHALL have no effect on the state.
REQ-022 Buffer data registers SHALL NOT need reset; only the occupancy state is reset.

Reset
REQ-023 When rst=1 at a rising edge, the next state SHALL be occupancy=0, out_valid=0 and fifo_pop=0 while rst is high, regardless of other inputs.
REQ-024 rst mid-transfer SHALL discard both buffered entries; after rst deasserts, the first output SHALL be the FIFO head present at that time.
REQ-025 Out of reset with fifo_empty=1, all outputs SHALL be stable: fifo_pop=0, out_valid=0, occupancy=0.

Verification
REQ-026 Reset, then FIFO head A with fifo_empty=0 in cycle 0 and out_ready=1 -> fifo_pop=1 in cycle 0; out_valid=1, out_data=A in cycle 1.
REQ-027 FIFO streams A,B,C,D with out_ready=0 -> pops A,B only, occupancy=2, fifo_pop=0; then out_ready=1 -> outputs A,B,C,D on consecutive cycles, none lost.
REQ-028 Continuous stream with out_ready=1 -> one output per cycle, occupancy stays 1, order preserved.
REQ-029 occupancy=2 plus a FIFO entry pending, flush=1 for one cycle -> fifo_pop=0 that cycle, then occupancy=0, out_valid=0; the next output is the first FIFO entry popped after flush.
REQ-030 occupancy=1 (head X), push Y and dequeue in the same cycle -> next cycle occupancy=1, out_data=Y.
REQ-031 Random out_ready and fifo_empty patterns over 10000 cycles checked against a reference queue -> order exact, occupancy never exceeds 2, no fifo_pop while fifo_empty=1.

Source files
------------

// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain, its upstream show-ahead FIFO and the downstream consumer.
// master = the drain block itself, slave = the surrounding environment.
interface fifo_drain_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_pop_data;
    logic                  fifo_pop;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [1:0]            occupancy;

    modport master (
        input  fifo_empty, fifo_pop_data, out_ready,
        output fifo_pop, out_valid, out_data, occupancy
    );

    modport slave (
        output fifo_empty, fifo_pop_data, out_ready,
        input  fifo_pop, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/fifo_drain.sv
// Two-entry skid buffer draining a show-ahead FIFO; out_valid/out_data come from registers,
// and fifo_pop never depends on out_ready.
module fifo_drain #(
    parameter int DATA_WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    fifo_drain_if.master  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_slot0;
    logic [DATA_WIDTH-1:0] r_slot1;

    logic                  w_push;
    logic                  w_deq;

    // Accepting only on occupancy is what keeps out_ready off the fifo_pop path.
    assign w_push = ~bus.fifo_empty & ~flush & ~rst & (r_state != TWO);
    assign w_deq  = r_out_valid & bus.out_ready;

    assign bus.fifo_pop  = w_push;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_slot0;
    assign bus.occupancy = r_state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_deq) begin
                        r_state <= TWO;
                    end else if (!w_push && w_deq) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_deq) begin
                        r_state <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: payload registers are not reset; r_out_valid/r_state qualify them, so reset would only cost area.
    always_ff @(posedge clk) begin
        case (r_state)
            EMPTY: begin
                if (w_push) r_slot0 <= bus.fifo_pop_data;
            end
            ONE: begin
                if (w_push && w_deq) r_slot0 <= bus.fifo_pop_data;
                else if (w_push)     r_slot1 <= bus.fifo_pop_data;
            end
            TWO: begin
                if (w_deq) r_slot0 <= r_slot1;
            end
            default: ;
        endcase
    end
endmodule
